// File: rtl/dct_mac_pipe.sv
// Pipelined signed multiply-accumulate for the DCT datapath: TERMS products per result.
// Define DCT_MAC_ROUND_EN to round/saturate the result to RWIDTH bits (FRAC bits dropped).
module dct_mac_pipe #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 12,
  parameter int TERMS  = 8,
  parameter int RWIDTH = 11,
  parameter int FRAC   = 10,
  localparam int PWIDTH = DWIDTH + CWIDTH,
  localparam int AWIDTH = PWIDTH + $clog2(TERMS),
  localparam int TCW    = $clog2(TERMS),
`ifdef DCT_MAC_ROUND_EN
  localparam int OW     = RWIDTH
`else
  localparam int OW     = AWIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [CWIDTH-1:0] coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     dout,
  output logic [TCW-1:0]           term_cnt
);

  logic                     en_s;
  logic                     accept_s;
  logic                     load_s;
  logic                     rdy_r;
  logic                     s1_valid_r;
  logic signed [PWIDTH-1:0] mult_res_r;
  logic signed [PWIDTH-1:0] prod_s;
  logic signed [AWIDTH-1:0] acc_r;
  logic signed [AWIDTH-1:0] mult_ext_s;
  logic signed [AWIDTH-1:0] acc_final_s;
  logic signed [OW-1:0]     dout_next_s;

`ifdef DCT_MAC_ROUND_EN
  // Round half toward +inf, then clamp into the signed RWIDTH range.
  function automatic logic signed [OW-1:0] round_sat(input logic signed [AWIDTH-1:0] a);
    logic signed [AWIDTH:0] biased;
    logic signed [AWIDTH:0] shifted;
    logic signed [AWIDTH:0] half;
    logic signed [AWIDTH:0] hi;
    logic signed [AWIDTH:0] lo;
    half             = '0;
    half[FRAC-1]     = 1'b1;
    hi               = '0;
    hi[RWIDTH-2:0]   = '1;
    lo               = ~hi;
    biased           = {a[AWIDTH-1], a} + half;
    shifted          = biased >>> FRAC;
    if (shifted > hi) begin
      round_sat = hi[OW-1:0];
    end else if (shifted < lo) begin
      round_sat = lo[OW-1:0];
    end else begin
      round_sat = shifted[OW-1:0];
    end
  endfunction
`endif

  assign en_s        = ~(out_valid & ~out_ready);
  assign in_ready    = en_s & rdy_r;
  assign accept_s    = in_valid & in_ready;
  assign prod_s      = PWIDTH'(din) * PWIDTH'(coef);
  assign mult_ext_s  = {{(AWIDTH-PWIDTH){mult_res_r[PWIDTH-1]}}, mult_res_r};
  assign acc_final_s = acc_r + mult_ext_s;
  assign load_s      = s1_valid_r & en_s & (term_cnt == TCW'(TERMS-1));

  // Output value selection: full-width sum or rounded/saturated sum.
  always_comb begin
    dout_next_s = '0;
`ifdef DCT_MAC_ROUND_EN
    dout_next_s = round_sat(acc_final_s);
`else
    dout_next_s = acc_final_s;
`endif
  end

  // Input side opens one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r <= 1'b0;
    end else begin
      rdy_r <= 1'b1;
    end
  end

  // Stage 1: register the full-width product of each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      mult_res_r <= '0;
    end else if (en_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        mult_res_r <= prod_s;
      end else begin
        mult_res_r <= mult_res_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      mult_res_r <= mult_res_r;
    end
  end

  // Stage 2: accumulate; term 0 restarts the sum so groups run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      term_cnt <= '0;
    end else if (s1_valid_r && en_s) begin
      if (term_cnt == TCW'(0)) begin
        acc_r <= mult_ext_s;
      end else begin
        acc_r <= acc_final_s;
      end
      term_cnt <= term_cnt + TCW'(1);
    end else begin
      acc_r    <= acc_r;
      term_cnt <= term_cnt;
    end
  end

  // Output register: a fresh result wins over a same-edge handshake clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      dout      <= dout_next_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      dout      <= dout;
    end else begin
      out_valid <= out_valid;
      dout      <= dout;
    end
  end

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Self-checking bench for dct_mac_pipe: directed scenarios plus randomized traffic
// checked against a sum-of-products reference model (honours DCT_MAC_ROUND_EN).
module tb_dct_mac_pipe;

  localparam int DWIDTH = 8;
  localparam int CWIDTH = 12;
  localparam int TERMS  = 8;
  localparam int RWIDTH = 11;
  localparam int FRAC   = 10;
  localparam int AWIDTH = DWIDTH + CWIDTH + $clog2(TERMS);
`ifdef DCT_MAC_ROUND_EN
  localparam int OW = RWIDTH;
  localparam longint E_BASIC = 0;
  localparam longint E_EXTREME = 1023;
  localparam longint E_B2B0 = 0;
  localparam longint E_B2B1 = 0;
  localparam longint E_MID = 0;
`else
  localparam int OW = AWIDTH;
  localparam longint E_BASIC = 8;
  localparam longint E_EXTREME = 2097152;
  localparam longint E_B2B0 = 36;
  localparam longint E_B2B1 = 100;
  localparam longint E_MID = 32;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready;
  logic out_valid;
  logic signed [DWIDTH-1:0] din = '0;
  logic signed [CWIDTH-1:0] coef = '0;
  logic signed [OW-1:0] dout;
  logic [$clog2(TERMS)-1:0] term_cnt;

  int compared = 0;
  int mismatched = 0;
  int tmo = 0;
  longint exp_q[$];
  longint obs_q[$];
  longint partial = 0;
  int nbeats = 0;

  always #5 clk = ~clk;

  dct_mac_pipe #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .TERMS(TERMS), .RWIDTH(RWIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din), .coef(coef),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .term_cnt(term_cnt)
  );

  function automatic longint model_out(input longint s);
`ifdef DCT_MAC_ROUND_EN
    longint sc, b, q, hi, lo;
    sc = longint'(1) << FRAC;
    b  = s + sc / 2;
    if (b >= 0) q = b / sc;
    else q = -((-b + sc - 1) / sc);
    hi = (longint'(1) << (RWIDTH - 1)) - 1;
    lo = -(longint'(1) << (RWIDTH - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
`else
    return s;
`endif
  endfunction

  // Reference model and output monitor, sampled mid-cycle for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
      partial = 0;
      nbeats = 0;
    end else begin
      if (out_valid && out_ready) obs_q.push_back(longint'(dout));
      if (in_valid && in_ready) begin
        partial += longint'(din) * longint'(coef);
        nbeats++;
        if (nbeats == TERMS) begin
          exp_q.push_back(model_out(partial));
          partial = 0;
          nbeats = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic signed [DWIDTH-1:0] d, input logic signed [CWIDTH-1:0] c);
    bit a;
    int n;
    in_valid = 1'b1;
    din = d;
    coef = c;
    n = 0;
    do begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!a && n < 100);
    if (!a) tmo++;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    compared++; if (term_cnt !== '0) begin mismatched++; $display("FAIL reset_term_cnt: got %0d expected 0", term_cnt); end
    compared++; if (dout !== '0) begin mismatched++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int k = 0; k < TERMS; k++) begin
      drive_beat(8'sd1, 12'sd1);
      if (k == 2) begin
        compared++; if (term_cnt !== 3'd2) begin mismatched++; $display("FAIL basic_term_cnt: got %0d expected 2", term_cnt); end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_latency_early: got %0b expected 0", out_valid); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_latency: got %0b expected 1", out_valid); end
    compared++; if (longint'(dout) !== E_BASIC) begin mismatched++; $display("FAIL basic_dout: got %0d expected %0d", dout, E_BASIC); end
    compared++; if (term_cnt !== 3'd0) begin mismatched++; $display("FAIL basic_term_wrap: got %0d expected 0", term_cnt); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_valid_clear: got %0b expected 0", out_valid); end
    compared++; if (tmo !== 0) begin mismatched++; $display("FAIL basic_timeout: got %0d expected 0", tmo); end
  endtask

  task automatic test_signed_extreme();
    apply_reset();
    for (int k = 0; k < TERMS; k++) drive_beat(-8'sd128, -12'sd2048);
    drain();
    compared++;
    if (obs_q.size() !== 1) begin mismatched++; $display("FAIL extreme_count: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] !== E_EXTREME) begin mismatched++; $display("FAIL extreme_dout: got %0d expected %0d", obs_q[0], E_EXTREME); end
  endtask

  task automatic test_back_to_back();
    time t0;
    apply_reset();
    t0 = $time;
    for (int k = 1; k <= 16; k++) drive_beat(8'(k), 12'sd1);
    compared++; if (($time - t0) !== 160) begin mismatched++; $display("FAIL b2b_rate: got %0t expected 160", $time - t0); end
    drain();
    compared++; if (obs_q.size() !== 2) begin mismatched++; $display("FAIL b2b_count: got %0d expected 2", obs_q.size()); end
    else begin
      compared++; if (obs_q[0] !== E_B2B0) begin mismatched++; $display("FAIL b2b_first: got %0d expected %0d", obs_q[0], E_B2B0); end
      compared++; if (obs_q[1] !== E_B2B1) begin mismatched++; $display("FAIL b2b_second: got %0d expected %0d", obs_q[1], E_B2B1); end
    end
  endtask

  task automatic test_backpressure();
    int idx, cyc, stall;
    bit a, held_seen;
    logic signed [OW-1:0] held;
    apply_reset();
    out_ready = 1'b0;
    idx = 0; cyc = 0; stall = 0; held_seen = 1'b0; held = '0;
    in_valid = 1'b1; din = 8'sd1; coef = 12'sd1;
    while (idx < 17 && cyc < 300) begin
      @(negedge clk);
      a = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
        if (!held_seen) begin held = dout; held_seen = 1'b1; end
        else begin
          compared++; if (dout !== held) begin mismatched++; $display("FAIL bp_dout_stable: got %0d expected %0d", dout, held); end
        end
        stall++;
      end
      @(posedge clk); #1;
      cyc++;
      if (stall >= 6) out_ready = 1'b1;
      if (a) begin idx++; din = 8'(idx + 1); end
    end
    compared++; if (idx !== 17) begin mismatched++; $display("FAIL bp_beats: got %0d expected 17", idx); end
    drain();
    compared++; if (obs_q.size() !== 2 || exp_q.size() !== 2) begin mismatched++; $display("FAIL bp_count: got %0d expected 2", obs_q.size()); end
    else begin
      compared++; if (obs_q[0] !== E_B2B0 || obs_q[0] !== exp_q[0]) begin mismatched++; $display("FAIL bp_first: got %0d expected %0d", obs_q[0], E_B2B0); end
      compared++; if (obs_q[1] !== E_B2B1 || obs_q[1] !== exp_q[1]) begin mismatched++; $display("FAIL bp_second: got %0d expected %0d", obs_q[1], E_B2B1); end
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    for (int k = 0; k < 5; k++) drive_beat(8'sd3, 12'sd3);
    in_valid = 1'b0;
    compared++; if (term_cnt !== 3'd4) begin mismatched++; $display("FAIL mid_term_before: got %0d expected 4", term_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
    compared++; if (term_cnt !== 3'd0) begin mismatched++; $display("FAIL mid_term_cnt: got %0d expected 0", term_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < TERMS; k++) drive_beat(8'sd2, 12'sd2);
    drain();
    compared++;
    if (obs_q.size() !== 1) begin mismatched++; $display("FAIL mid_count: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] !== E_MID) begin mismatched++; $display("FAIL mid_dout: got %0d expected %0d", obs_q[0], E_MID); end
  endtask

`ifdef DCT_MAC_ROUND_EN
  task automatic test_rounding();
    longint want[4];
    int cv[4];
    want = '{1, 0, 1, -1};
    cv = '{0, 511, 512, -513};
    apply_reset();
    for (int k = 0; k < TERMS; k++) drive_beat(8'sd16, 12'sd8);
    for (int g = 1; g < 4; g++)
      for (int k = 0; k < TERMS; k++) drive_beat(8'sd1, (k == 0) ? 12'(cv[g]) : 12'sd0);
    drain();
    compared++; if (obs_q.size() !== 4) begin mismatched++; $display("FAIL round_count: got %0d expected 4", obs_q.size()); end
    else begin
      for (int g = 0; g < 4; g++) begin
        compared++; if (obs_q[g] !== want[g]) begin mismatched++; $display("FAIL round_%0d: got %0d expected %0d", g, obs_q[g], want[g]); end
      end
    end
  endtask
`endif

  task automatic test_random();
    int n;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      din = 8'($urandom);
      coef = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();
    compared++; if (obs_q.size() !== exp_q.size() || exp_q.size() == 0) begin mismatched++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      compared++; if (obs_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand_result_%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
    end
    compared++; if (tmo !== 0) begin mismatched++; $display("FAIL beat_timeout: got %0d expected 0", tmo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_extreme();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
`ifdef DCT_MAC_ROUND_EN
    test_rounding();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
